// File: rtl/config_pkg.sv
// ============================================================================
// Module      : config_pkg
// Description : PMA attribute type, rule configuration struct and helpers
//               shared by the sequential PMA checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package config_pkg;

    localparam int unsigned PmaGranuleBits = 12;
    localparam int unsigned MaxPmaRules    = 8;
    localparam int unsigned RuleIdxBits    = $clog2(MaxPmaRules);

    typedef struct packed {
        logic non_idempotent;
        logic executable;
        logic cacheable;
    } pma_attr_t;

    typedef logic [MaxPmaRules-1:0][63:0] pma_rule_vec_t;

    typedef struct packed {
        int unsigned   NrNonIdempotentRules;
        pma_rule_vec_t NonIdempotentAddrBase;
        pma_rule_vec_t NonIdempotentLength;
        int unsigned   NrExecuteRegionRules;
        pma_rule_vec_t ExecuteRegionAddrBase;
        pma_rule_vec_t ExecuteRegionLength;
        int unsigned   NrCachedRegionRules;
        pma_rule_vec_t CachedRegionAddrBase;
        pma_rule_vec_t CachedRegionLength;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '0;

    // End of region is formed at 65 bits so a region ending at 2^64 still matches.
    function automatic logic range_check(input logic [63:0] base,
                                         input logic [63:0] len,
                                         input logic [63:0] addr);
        logic [64:0] w_end;
        w_end = {1'b0, base} + {1'b0, len};
        return (addr >= base) && ({1'b0, addr} < w_end);
    endfunction

    function automatic int unsigned pma_scan_len(input cva6_cfg_t cfg);
        int unsigned n;
        n = cfg.NrNonIdempotentRules;
        if (cfg.NrExecuteRegionRules > n) n = cfg.NrExecuteRegionRules;
        if (cfg.NrCachedRegionRules > n)  n = cfg.NrCachedRegionRules;
        if (n == 0)           n = 1;
        if (n > MaxPmaRules)  n = MaxPmaRules;
        return n;
    endfunction

    function automatic bit pma_cfg_aligned(input cva6_cfg_t cfg);
        bit ok;
        ok = 1'b1;
        for (int unsigned i = 0; i < MaxPmaRules; i++) begin
            if (i < cfg.NrNonIdempotentRules &&
                ((cfg.NonIdempotentAddrBase[i][PmaGranuleBits-1:0] != '0) ||
                 (cfg.NonIdempotentLength[i][PmaGranuleBits-1:0] != '0))) ok = 1'b0;
            if (i < cfg.NrExecuteRegionRules &&
                ((cfg.ExecuteRegionAddrBase[i][PmaGranuleBits-1:0] != '0) ||
                 (cfg.ExecuteRegionLength[i][PmaGranuleBits-1:0] != '0))) ok = 1'b0;
            if (i < cfg.NrCachedRegionRules &&
                ((cfg.CachedRegionAddrBase[i][PmaGranuleBits-1:0] != '0) ||
                 (cfg.CachedRegionLength[i][PmaGranuleBits-1:0] != '0))) ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

`default_nettype wire

// File: rtl/pma_rule_eval.sv
// ============================================================================
// Module      : pma_rule_eval
// Description : Combinational match of one rule index against an address for
//               the non-idempotent, executable and cacheable categories.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pma_rule_eval
    import config_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg = cva6_cfg_empty
) (
    input  logic [RuleIdxBits-1:0] i_k,
    input  logic [63:0]            i_addr,
    output pma_attr_t              o_hit
);

    logic [31:0] w_k;
    assign w_k = 32'(i_k);

    // A category only sees rule k when k is below its own rule count.
    always_comb begin
        o_hit = '0;
        if (w_k < CVA6Cfg.NrNonIdempotentRules)
            o_hit.non_idempotent = range_check(CVA6Cfg.NonIdempotentAddrBase[i_k],
                                               CVA6Cfg.NonIdempotentLength[i_k], i_addr);
        if (w_k < CVA6Cfg.NrExecuteRegionRules)
            o_hit.executable = range_check(CVA6Cfg.ExecuteRegionAddrBase[i_k],
                                           CVA6Cfg.ExecuteRegionLength[i_k], i_addr);
        if (w_k < CVA6Cfg.NrCachedRegionRules)
            o_hit.cacheable = range_check(CVA6Cfg.CachedRegionAddrBase[i_k],
                                          CVA6Cfg.CachedRegionLength[i_k], i_addr);
    end

endmodule

`default_nettype wire

// File: rtl/pma_seq_checker.sv
// ============================================================================
// Module      : pma_seq_checker
// Description : Round-robin arbitrated PMA lookup that scans one rule index
//               per cycle. Optional one-entry result cache: PMA_RESULT_CACHE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pma_seq_checker
    import config_pkg::*;
#(
    parameter cva6_cfg_t   CVA6Cfg = cva6_cfg_empty,
    parameter int unsigned NrReq   = 2
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   flush_i,
    input  logic [NrReq-1:0]       req_valid_i,
    output logic [NrReq-1:0]       req_ready_o,
    input  logic [NrReq-1:0][63:0] req_addr_i,
    output logic [NrReq-1:0]       rsp_valid_o,
    output pma_attr_t              rsp_attr_o
);

    localparam int unsigned IdxW    = (NrReq > 1) ? $clog2(NrReq) : 1;
    localparam int unsigned ScanLen = pma_scan_len(CVA6Cfg);
    localparam logic [RuleIdxBits-1:0] LastK = RuleIdxBits'(ScanLen - 1);
    localparam logic ExecDefault = (CVA6Cfg.NrExecuteRegionRules == 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]             r_state;
    logic [RuleIdxBits-1:0] r_k;
    logic [IdxW-1:0]        r_ptr;
    logic [IdxW-1:0]        r_idx;
    logic [63:0]            r_addr;
    pma_attr_t              r_acc;
    pma_attr_t              r_attr;

    logic                   w_found;
    logic [IdxW-1:0]        w_winner;
    logic                   w_accept;
    logic [63:0]            w_sel_addr;
    pma_attr_t              w_rule_hit;
    pma_attr_t              w_acc_next;
    pma_attr_t              w_final;
    logic                   w_scan_done;
    logic                   w_cache_hit;
    pma_attr_t              w_cached_attr;

    function automatic logic [IdxW-1:0] rr_add(input logic [IdxW-1:0] base,
                                               input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NrReq) s = s - NrReq;
        return s[IdxW-1:0];
    endfunction

    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned i = 0; i < NrReq; i++) begin
            if (!w_found && req_valid_i[rr_add(r_ptr, i)]) begin
                w_found  = 1'b1;
                w_winner = rr_add(r_ptr, i);
            end
        end
    end

    // Grants are held off while in reset so nothing is offered before IDLE is real.
    assign w_accept   = rst_ni && (r_state == S_IDLE) && !flush_i && w_found;
    assign w_sel_addr = req_addr_i[w_winner];

    always_comb begin
        req_ready_o = '0;
        if (w_accept) req_ready_o[w_winner] = 1'b1;
    end

    always_comb begin
        rsp_valid_o = '0;
        if ((r_state == S_RESP) && !flush_i) rsp_valid_o[r_idx] = 1'b1;
    end

    assign rsp_attr_o = r_attr;

    pma_rule_eval #(
        .CVA6Cfg (CVA6Cfg)
    ) u_rule_eval (
        .i_k    (r_k),
        .i_addr (r_addr),
        .o_hit  (w_rule_hit)
    );

    assign w_acc_next  = r_acc | w_rule_hit;
    assign w_scan_done = (r_state == S_SCAN) && !flush_i && (r_k == LastK);

    always_comb begin
        w_final = w_acc_next;
        if (ExecDefault) w_final.executable = 1'b1;
    end

`ifdef PMA_RESULT_CACHE_EN
    logic                           r_cache_vld;
    logic [63-PmaGranuleBits:0]     r_cache_tag;
    pma_attr_t                      r_cache_attr;

    assign w_cache_hit   = r_cache_vld && (r_cache_tag == w_sel_addr[63:PmaGranuleBits]);
    assign w_cached_attr = r_cache_attr;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cache_vld  <= 1'b0;
            r_cache_tag  <= '0;
            r_cache_attr <= '0;
        end else if (flush_i) begin
            r_cache_vld  <= 1'b0;
        end else if (w_scan_done) begin
            r_cache_vld  <= 1'b1;
            r_cache_tag  <= r_addr[63:PmaGranuleBits];
            r_cache_attr <= w_final;
        end
    end

    // Page-granular tagging is only sound when every region is page aligned.
    localparam bit CfgAligned = pma_cfg_aligned(CVA6Cfg);
    a_cfg_granule_aligned: assert property (@(posedge clk_i) disable iff (!rst_ni) CfgAligned);
`else
    assign w_cache_hit   = 1'b0;
    assign w_cached_attr = '0;
`endif

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_ptr   <= '0;
            r_idx   <= '0;
            r_addr  <= '0;
            r_acc   <= '0;
            r_attr  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ptr  <= rr_add(w_winner, 1);
                        r_idx  <= w_winner;
                        r_addr <= w_sel_addr;
                        r_k    <= '0;
                        r_acc  <= '0;
                        if (w_cache_hit) begin
                            r_state <= S_RESP;
                            r_attr  <= w_cached_attr;
                        end else begin
                            r_state <= S_SCAN;
                        end
                    end
                end
                S_SCAN: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                        r_k     <= '0;
                        r_acc   <= '0;
                    end else if (r_k == LastK) begin
                        r_state <= S_RESP;
                        r_k     <= '0;
                        r_acc   <= '0;
                        r_attr  <= w_final;
                    end else begin
                        r_k     <= r_k + 1'b1;
                        r_acc   <= w_acc_next;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    r_acc   <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pma_seq_checker.sv
// ============================================================================
// Module      : tb_pma_seq_checker
// Description : Randomized self-checking bench for pma_seq_checker against a
//               transaction-level reference model (honours PMA_RESULT_CACHE_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pma_seq_checker;
    import config_pkg::*;

    localparam logic [7:0][63:0] NI_BASE = {8{64'h0}};
    localparam logic [7:0][63:0] NI_LEN  = {{7{64'h0}}, 64'h1000};
    localparam logic [7:0][63:0] EX_BASE = {{6{64'h0}}, 64'h8000_0000, 64'h0};
    localparam logic [7:0][63:0] EX_LEN  = {{6{64'h0}}, 64'h10_0000, 64'h1000};
    localparam logic [7:0][63:0] CA_BASE = {{4{64'h0}}, 64'hFFFF_FFFF_FFFF_F000,
                                            64'hA000_0000, 64'h9000_0000, 64'h8000_0000};
    localparam logic [7:0][63:0] CA_LEN  = {{4{64'h0}}, 64'h1000, 64'h1000, 64'h2000, 64'h1000};
    localparam int NR_NI  = 1;
    localparam int NR_EX  = 2;
    localparam int NR_CA  = 4;
    localparam int SCAN_L = 4;

    localparam cva6_cfg_t C_CFG = '{
        NrNonIdempotentRules:  NR_NI, NonIdempotentAddrBase: NI_BASE, NonIdempotentLength: NI_LEN,
        NrExecuteRegionRules:  NR_EX, ExecuteRegionAddrBase: EX_BASE, ExecuteRegionLength: EX_LEN,
        NrCachedRegionRules:   NR_CA, CachedRegionAddrBase:  CA_BASE, CachedRegionLength:  CA_LEN
    };

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][63:0] req_addr;
    logic [1:0]       rsp_valid;
    pma_attr_t        rsp_attr;

    int n_checks = 0;
    int n_errors = 0;

    int          m_ptr;
    logic [2:0]  m_last_attr;
    bit          m_cv;
    logic [51:0] m_ctag;

    pma_seq_checker #(
        .CVA6Cfg (C_CFG),
        .NrReq   (2)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .flush_i     (flush),
        .req_valid_i (req_valid),
        .req_ready_o (req_ready),
        .req_addr_i  (req_addr),
        .rsp_valid_o (rsp_valid),
        .rsp_attr_o  (rsp_attr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic bit in_rules(input logic [63:0] a, input logic [7:0][63:0] b,
                                    input logic [7:0][63:0] l, input int n);
        for (int i = 0; i < n; i++)
            if (a >= b[i] && (a - b[i]) < l[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] ref_attr(input logic [63:0] a);
        logic ni, ex, ca;
        ni = in_rules(a, NI_BASE, NI_LEN, NR_NI);
        ex = (NR_EX == 0) ? 1'b1 : in_rules(a, EX_BASE, EX_LEN, NR_EX);
        ca = in_rules(a, CA_BASE, CA_LEN, NR_CA);
        return {ni, ex, ca};
    endfunction

    function automatic logic [63:0] rand_addr();
        logic [63:0] a;
        case ($urandom_range(0, 7))
            0: a = 64'h0;
            1: a = 64'h8000_0000;
            2: a = 64'h9000_0000;
            3: a = 64'hA000_0000;
            4: a = 64'hFFFF_FFFF_FFFF_F000;
            5: a = 64'h8000_F000;
            default: a = {32'($urandom), 32'($urandom)};
        endcase
        if ($urandom_range(0, 1) == 1) a = a + 64'($urandom_range(0, 16'h2FFF));
        return a;
    endfunction

    // Called just after a falling edge with the DUT idle; returns on a falling edge.
    task automatic run_req(input logic [1:0] mask, input logic [63:0] a0, input logic [63:0] a1);
        int win, lat, exp_lat;
        logic [63:0] addr;
        logic [2:0]  exp;
        bit hit, seen;
        req_valid   = mask;
        req_addr[0] = a0;
        req_addr[1] = a1;
        #1;
        check("attr_hold", 64'(rsp_attr), 64'(m_last_attr));
        win = -1;
        for (int off = 0; off < 2; off++)
            if (win < 0 && mask[(m_ptr + off) % 2]) win = (m_ptr + off) % 2;
        check("grant", 64'(req_ready), 64'(1 << win));
        addr = (win == 1) ? a1 : a0;
        exp  = ref_attr(addr);
`ifdef PMA_RESULT_CACHE_EN
        hit = m_cv && (m_ctag == addr[63:12]);
`else
        hit = 1'b0;
`endif
        exp_lat = hit ? 1 : SCAN_L + 1;
        m_ptr = (win + 1) % 2;
        @(posedge clk);
        @(negedge clk);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= 20) begin
            req_valid   = 2'b11;
            req_addr[0] = rand_addr();
            req_addr[1] = rand_addr();
            #1;
            if (rsp_valid != 2'b00) begin
                seen = 1'b1;
            end else begin
                check("no_grant_busy", 64'(req_ready), 64'h0);
                @(negedge clk);
                lat++;
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("rsp_idx", 64'(rsp_valid), 64'(1 << win));
        check("rsp_attr", 64'(rsp_attr), 64'(exp));
        check("no_grant_resp", 64'(req_ready), 64'h0);
        req_valid = 2'b00;
        m_last_attr = exp;
        if (!hit) begin
            m_cv   = 1'b1;
            m_ctag = addr[63:12];
        end
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        bit seen;
        rst_n = 1'b0;
        flush = 1'b0;
        req_valid = 2'b11;
        req_addr[0] = 64'h800;
        req_addr[1] = 64'h800;
        m_ptr = 0; m_last_attr = 3'b000; m_cv = 1'b0; m_ctag = '0;
        repeat (2) @(negedge clk);
        #1;
        check("reset_ready", 64'(req_ready), 64'h0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
        check("reset_attr", 64'(rsp_attr), 64'h0);
        rst_n = 1'b1;
        req_valid = 2'b00;
        @(negedge clk);

        run_req(2'b01, 64'h800, 64'h0);

        // Reset in the middle of a scan.
        req_valid   = 2'b10;
        req_addr[1] = 64'h8000_0010;
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b11;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_mid_attr", 64'(rsp_attr), 64'h0);
        check("rst_mid_ready", 64'(req_ready), 64'h0);
        check("rst_mid_rsp_valid", 64'(rsp_valid), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req_valid = 2'b00;
        m_ptr = 0; m_last_attr = 3'b000; m_cv = 1'b0;
        @(negedge clk);
        run_req(2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h800);

        for (int i = 0; i < 4; i++) run_req(2'b11, rand_addr(), rand_addr());

        run_req(2'b01, 64'h8000_0010, 64'h0);
        run_req(2'b01, 64'h8000_0FF0, 64'h0);
        run_req(2'b01, 64'h8000_1000, 64'h0);

        // Flush while scanning rule index 2.
        req_valid   = 2'b01;
        req_addr[0] = 64'h800;
        @(posedge clk);
        @(negedge clk);
        m_ptr = 1;
        req_valid = 2'b00;
        @(negedge clk);
        @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_scan_rsp", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        flush = 1'b0;
        m_cv  = 1'b0;
        seen  = 1'b0;
        repeat (8) begin
            #1;
            if (rsp_valid != 2'b00) seen = 1'b1;
            @(negedge clk);
        end
        check("flush_no_rsp", 64'(seen), 64'h0);
        run_req(2'b01, 64'h800, 64'h0);

        // Flush in the response cycle; same address keeps the held attribute unambiguous.
        req_valid   = 2'b01;
        req_addr[0] = 64'h900;
        @(posedge clk);
        @(negedge clk);
        m_ptr = 1;
        req_valid = 2'b00;
        repeat (SCAN_L) @(negedge clk);
        flush = 1'b1;
        #1;
        check("flush_resp_rsp", 64'(rsp_valid), 64'h0);
        @(negedge clk);
        flush = 1'b0;
        m_cv  = 1'b0;
        #1;
        check("flush_resp_after", 64'(rsp_valid), 64'h0);
        @(negedge clk);

        // Flush while idle with requests pending.
        req_valid = 2'b11;
        flush     = 1'b1;
        #1;
        check("flush_idle_ready", 64'(req_ready), 64'h0);
        @(negedge clk);
        flush     = 1'b0;
        req_valid = 2'b00;
        m_cv      = 1'b0;
        #1;
        check("flush_idle_rsp", 64'(rsp_valid), 64'h0);
        @(negedge clk);

        for (int i = 0; i < 30; i++)
            run_req(2'($urandom_range(1, 3)), rand_addr(), rand_addr());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
